// File: rtl/mcs4_bus_hub.sv
// rtl/mcs4_bus_hub.sv - MCS-4 shared data-bus hub: merge, phase tracking, contention, bank latch (option: MCS4_BUS_HUB_PRIORITY_EN)
module mcs4_bus_hub #(
    parameter  int N_ROM      = 2,
    parameter  int RAM_BANKS  = 4,
    parameter  int BANK_CHIPS = 4,
    parameter  int ERR_CNT_W  = 8,
    localparam int N_AGENT    = 1 + N_ROM + RAM_BANKS * BANK_CHIPS,
    localparam int AG_W       = $clog2(N_AGENT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sync,
    input  logic [N_AGENT*4-1:0]   agent_dout,
    input  logic [N_AGENT-1:0]     agent_den,
    input  logic [RAM_BANKS-1:0]   cm_ram,
    input  logic                   err_clr,
    output logic [3:0]             dbus,
    output logic [2:0]             phase,
    output logic                   phase_valid,
    output logic                   sync_lost,
    output logic                   contention,
    output logic [AG_W-1:0]        owner,
    output logic                   owner_valid,
    output logic [ERR_CNT_W-1:0]   err_cnt,
    output logic [RAM_BANKS-1:0]   bank_sel
);

    typedef enum logic {ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [2:0]             phase_q, phase_d;
    logic                   sync_lost_q, sync_lost_d;
    logic                   contention_q, contention_d;
    logic [AG_W-1:0]        owner_q, owner_d;
    logic                   owner_valid_q, owner_valid_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [RAM_BANKS-1:0]   bank_sel_q, bank_sel_d;

    // Bus merge: OR of enabled drivers, or lowest-index driver only when priority is enabled
    always_comb begin
        dbus = 4'h0;
`ifdef MCS4_BUS_HUB_PRIORITY_EN
        for (int i = N_AGENT - 1; i >= 0; i--) begin
            if (agent_den[i]) begin
                dbus = agent_dout[4*i +: 4];
            end
        end
`else
        for (int i = 0; i < N_AGENT; i++) begin
            dbus = dbus | (agent_dout[4*i +: 4] & {4{agent_den[i]}});
        end
`endif
    end

    // Contention, owner, error counter and bank latch next values
    always_comb begin
        logic seen;
        logic multi;
        seen          = 1'b0;
        multi         = 1'b0;
        owner_d       = '0;
        owner_valid_d = 1'b0;
        for (int i = 0; i < N_AGENT; i++) begin
            multi = multi | (seen & agent_den[i]);
            seen  = seen | agent_den[i];
        end
        for (int i = N_AGENT - 1; i >= 0; i--) begin
            if (agent_den[i]) begin
                owner_d       = AG_W'(i);
                owner_valid_d = 1'b1;
            end
        end
        contention_d = multi;

        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (multi && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end

        bank_sel_d = bank_sel_q;
        if ((state_q == ST_LOCKED) && (phase_q == 3'd2) && (cm_ram != '0)) begin
            bank_sel_d = cm_ram;
        end
    end

    // State register: tracker state plus every registered output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_UNLOCKED;
            phase_q       <= 3'd0;
            sync_lost_q   <= 1'b0;
            contention_q  <= 1'b0;
            owner_q       <= '0;
            owner_valid_q <= 1'b0;
            err_cnt_q     <= '0;
            bank_sel_q    <= RAM_BANKS'(1);
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            sync_lost_q   <= sync_lost_d;
            contention_q  <= contention_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            err_cnt_q     <= err_cnt_d;
            bank_sel_q    <= bank_sel_d;
        end
    end

    // Tracker next state: lock on sync, expect sync exactly at X3, relock on early sync
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        sync_lost_d = 1'b0;
        case (state_q)
            ST_UNLOCKED: begin
                phase_d = 3'd0;
                if (sync) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (sync) begin
                    sync_lost_d = (phase_q != 3'd7);
                    phase_d     = 3'd0;
                end else if (phase_q == 3'd7) begin
                    sync_lost_d = 1'b1;
                    state_d     = ST_UNLOCKED;
                    phase_d     = 3'd0;
                end else begin
                    phase_d = phase_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_UNLOCKED;
                phase_d = 3'd0;
            end
        endcase
    end

    // Outputs driven straight from the registers
    always_comb begin
        phase       = phase_q;
        phase_valid = (state_q == ST_LOCKED);
        sync_lost   = sync_lost_q;
        contention  = contention_q;
        owner       = owner_q;
        owner_valid = owner_valid_q;
        err_cnt     = err_cnt_q;
        bank_sel    = bank_sel_q;
    end

endmodule

// File: tb/tb_mcs4_bus_hub.sv
// tb/tb_mcs4_bus_hub.sv - scoreboard bench for mcs4_bus_hub (default and minimal populations)
module tb_mcs4_bus_hub;

    logic        clk;
    logic        rst;
    logic        sync;
    logic [75:0] agent_dout;
    logic [18:0] agent_den;
    logic [3:0]  cm_ram;
    logic        err_clr;

    logic [3:0]  dbus0, dbus1;
    logic [2:0]  phase0, phase1;
    logic        pv0, pv1, sl0, sl1, ct0, ct1, ov0, ov1;
    logic [4:0]  owner0;
    logic [1:0]  owner1;
    logic [7:0]  err0, err1;
    logic [3:0]  bank0;
    logic [0:0]  bank1;

    int errors = 0;
    int checks = 0;

    mcs4_bus_hub u_dut0 (
        .clk(clk), .rst(rst), .sync(sync), .agent_dout(agent_dout), .agent_den(agent_den),
        .cm_ram(cm_ram), .err_clr(err_clr), .dbus(dbus0), .phase(phase0), .phase_valid(pv0),
        .sync_lost(sl0), .contention(ct0), .owner(owner0), .owner_valid(ov0), .err_cnt(err0),
        .bank_sel(bank0)
    );

    mcs4_bus_hub #(.N_ROM(1), .RAM_BANKS(1), .BANK_CHIPS(1), .ERR_CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .sync(sync), .agent_dout(agent_dout[11:0]), .agent_den(agent_den[2:0]),
        .cm_ram(cm_ram[0:0]), .err_clr(err_clr), .dbus(dbus1), .phase(phase1), .phase_valid(pv1),
        .sync_lost(sl1), .contention(ct1), .owner(owner1), .owner_valid(ov1), .err_cnt(err1),
        .bank_sel(bank1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       locked;
        int       phase;
        bit       sync_lost;
        bit       cont;
        int       owner;
        bit       owner_valid;
        int       err;
        bit [3:0] bank;
    } mst_t;

    typedef struct {
        int   dbus;
        mst_t st;
    } rec_t;

    rec_t q0[$];
    rec_t q1[$];
    mst_t m0, m1;

    function automatic mst_t mreset();
        mst_t s;
        s.locked = 0; s.phase = 0; s.sync_lost = 0; s.cont = 0;
        s.owner = 0; s.owner_valid = 0; s.err = 0; s.bank = 4'b0001;
        return s;
    endfunction

    // Expected bus value straight from the merge rule
    function automatic int mbus(bit [75:0] dout, bit [18:0] den, int na);
        int v = 0;
        for (int i = 0; i < na; i++) begin
            if (den[i]) begin
`ifdef MCS4_BUS_HUB_PRIORITY_EN
                return int'(dout[4*i +: 4]);
`else
                v = v | int'(dout[4*i +: 4]);
`endif
            end
        end
        return v;
    endfunction

    // One clock of the behavioural model
    function automatic mst_t mstep(mst_t s, bit sy, bit [18:0] den, bit [3:0] cm, bit clr,
                                   int na, int nb);
        mst_t n = s;
        int cnt = 0;
        int first = -1;
        bit [3:0] cmm;
        for (int i = 0; i < na; i++) begin
            if (den[i]) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        n.cont        = (cnt >= 2);
        n.owner_valid = (first >= 0);
        n.owner       = (first >= 0) ? first : 0;
        if (clr) n.err = 0;
        else if (cnt >= 2 && s.err < 255) n.err = s.err + 1;
        cmm = cm & 4'((1 << nb) - 1);
        if (s.locked && s.phase == 2 && cmm != 0) n.bank = cmm;
        n.sync_lost = 0;
        if (!s.locked) begin
            n.phase = 0;
            if (sy) n.locked = 1;
        end else if (sy) begin
            n.sync_lost = (s.phase != 7);
            n.phase = 0;
        end else if (s.phase == 7) begin
            n.sync_lost = 1;
            n.locked = 0;
            n.phase = 0;
        end else begin
            n.phase = s.phase + 1;
        end
        return n;
    endfunction

    // Drive one cycle of inputs and queue what the hub must present during it
    task automatic step(bit r, bit sy, bit [18:0] den, bit [75:0] dout, bit [3:0] cm, bit clr);
        rec_t rc;
        @(posedge clk);
        #2;
        rst = r; sync = sy; agent_den = den; agent_dout = dout; cm_ram = cm; err_clr = clr;
        if (!r) begin
            m0 = mreset();
            m1 = mreset();
        end
        rc.dbus = mbus(dout, den, 19); rc.st = m0; q0.push_back(rc);
        rc.dbus = mbus(dout, den, 3);  rc.st = m1; q1.push_back(rc);
        if (r) begin
            m0 = mstep(m0, sy, den, cm, clr, 19, 4);
            m1 = mstep(m1, sy, den, cm, clr, 3, 1);
        end
    endtask

    function automatic bit [75:0] rdout();
        return {12'($urandom), $urandom, $urandom};
    endfunction

    function automatic bit aligned_sync();
        return m0.locked && m0.phase == 7;
    endfunction

    function automatic bit [18:0] rden();
        case ($urandom % 4)
            0: return 19'd0;
            1: return 19'd1 << ($urandom % 19);
            2: return 19'($urandom & $urandom & $urandom);
            default: return 19'($urandom);
        endcase
    endfunction

    task automatic cmp(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop one expectation per cycle per instance and compare mid-cycle
    always @(negedge clk) begin
        rec_t r;
        if (q0.size() > 0) begin
            r = q0.pop_front();
            cmp("d0_dbus", int'(dbus0), r.dbus);
            cmp("d0_phase", int'(phase0), r.st.phase);
            cmp("d0_phase_valid", int'(pv0), int'(r.st.locked));
            cmp("d0_sync_lost", int'(sl0), int'(r.st.sync_lost));
            cmp("d0_contention", int'(ct0), int'(r.st.cont));
            cmp("d0_owner_valid", int'(ov0), int'(r.st.owner_valid));
            if (r.st.owner_valid) cmp("d0_owner", int'(owner0), r.st.owner);
            cmp("d0_err_cnt", int'(err0), r.st.err);
            cmp("d0_bank_sel", int'(bank0), int'(r.st.bank));
        end
        if (q1.size() > 0) begin
            r = q1.pop_front();
            cmp("d1_dbus", int'(dbus1), r.dbus);
            cmp("d1_phase", int'(phase1), r.st.phase);
            cmp("d1_phase_valid", int'(pv1), int'(r.st.locked));
            cmp("d1_sync_lost", int'(sl1), int'(r.st.sync_lost));
            cmp("d1_contention", int'(ct1), int'(r.st.cont));
            cmp("d1_owner_valid", int'(ov1), int'(r.st.owner_valid));
            if (r.st.owner_valid) cmp("d1_owner", int'(owner1), r.st.owner);
            cmp("d1_err_cnt", int'(err1), r.st.err);
            cmp("d1_bank_sel", int'(bank1), int'(r.st.bank[0]));
        end
    end

    initial begin
        bit [75:0] d;
        rst = 1'b0; sync = 1'b0; agent_den = '0; agent_dout = '0; cm_ram = '0; err_clr = 1'b0;
        m0 = mreset();
        m1 = mreset();

        // Reset held with toggling inputs
        for (int i = 0; i < 6; i++) step(0, 1'($urandom), rden(), rdout(), 4'($urandom), 1'($urandom));

        // Lock: first sync at cycle 10, then aligned for three instruction cycles
        for (int i = 0; i < 10; i++) step(1, 0, 19'd0, rdout(), 4'd0, 0);
        step(1, 1, 19'd0, rdout(), 4'd0, 0);
        for (int i = 0; i < 24; i++) step(1, aligned_sync(), 19'd0, rdout(), 4'd0, 0);

        // Bank select at A3, ignored at M1
        for (int i = 0; i < 16 && !(m0.locked && m0.phase == 2); i++) step(1, aligned_sync(), 19'd0, rdout(), 4'd0, 0);
        step(1, 0, 19'd0, rdout(), 4'b0100, 0);
        step(1, 0, 19'd0, rdout(), 4'b1000, 0);

        // Early sync at M1, then a missing sync at X3
        for (int i = 0; i < 16 && !(m0.locked && m0.phase == 3); i++) step(1, aligned_sync(), 19'd0, rdout(), 4'd0, 0);
        step(1, 1, 19'd0, rdout(), 4'd0, 0);
        for (int i = 0; i < 12; i++) step(1, 0, 19'd0, rdout(), 4'd0, 0);

        // Unlocked: cm_ram must be ignored
        for (int i = 0; i < 10; i++) step(1, 0, 19'd0, rdout(), 4'b0010, 0);

        // Contention between agents 0 and 2, saturating the counter, then a clear during contention
        d = '0; d[3:0] = 4'h3; d[11:8] = 4'h4;
        for (int i = 0; i < 300; i++) step(1, 0, 19'b101, d, 4'd0, 0);
        step(1, 0, 19'b101, d, 4'd0, 1);
        step(1, 0, 19'b101, d, 4'd0, 0);

        // Sole driver agent 2
        for (int i = 0; i < 4; i++) step(1, 0, 19'b100, rdout(), 4'd0, 0);

        // Randomised traffic with mostly aligned sync
        for (int i = 0; i < 3000; i++) begin
            bit sy;
            if (aligned_sync()) sy = ($urandom % 16) != 0;
            else if (!m0.locked) sy = ($urandom % 4) == 0;
            else sy = ($urandom % 40) == 0;
            step(($urandom % 500) != 0, sy, rden(), rdout(), 4'($urandom), ($urandom % 600) == 0);
        end

        for (int i = 0; i < 50 && (q0.size() > 0 || q1.size() > 0); i++) @(posedge clk);
        if (q0.size() > 0 || q1.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d/%0d expectations left, required 0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mcs4_bus_hub.md
Name: mcs4_bus_hub

Overview:
Parametrised shared 4-bit data-bus hub for MCS-4 systems with any CPU/ROM/RAM population, replacing hand-written OR trees in system tops. It does the following:
- Merges agent drivers onto one bus.
- Tracks the 8-phase instruction cycle from sync.
- Detects and counts bus contention.
- Latches the active RAM bank from cm_ram.
Sits between the i4004, i4001 and i4002 instances; agent 0 is always the CPU, then ROMs, then RAM chips in bank-major order.

Parameters:
N_ROM, 2, number of ROM agents (1..16)
RAM_BANKS, 4, number of RAM banks / cm_ram lines (1..4)
BANK_CHIPS, 4, RAM chips per bank (1..4)
ERR_CNT_W, 8, contention counter width
(local) N_AGENT = 1 + N_ROM + RAM_BANKS*BANK_CHIPS; AG_W = $clog2(N_AGENT)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
sync  in  1  CPU sync; high for one cycle, marks the next cycle as A1
agent_dout  in  N_AGENT*4  agent data outputs; agent i at bits [4i+3:4i]
agent_den  in  N_AGENT  per-agent drive enable
cm_ram  in  RAM_BANKS  CPU RAM bank command lines
err_clr  in  1  synchronous clear of err_cnt
dbus  out  4  merged data bus, combinational
phase  out  3  current phase: 0=A1, 1=A2, 2=A3, 3=M1, 4=M2, 5=X1, 6=X2, 7=X3
phase_valid  out  1  phase tracker locked
sync_lost  out  1  one-cycle pulse on sync misalignment
contention  out  1  one-cycle pulse, registered, >1 agent drove the previous cycle
owner  out  AG_W  lowest-index enabled agent of the previous cycle
owner_valid  out  1  at least one agent drove the previous cycle
err_cnt  out  ERR_CNT_W  saturating contention count
bank_sel  out  RAM_BANKS  latched one-hot active bank

Behaviour:
Reset (rst=0, async) values:
- phase=0, phase_valid=0, sync_lost=0, contention=0.
- owner=0, owner_valid=0, err_cnt=0.
- bank_sel = one-hot bit 0.
- Tracker FSM in UNLOCKED.
- Reset mid-cycle aborts tracking; the hub relocks only on the next sync.

Bus merge:
- dbus = OR over i of (agent_dout[i] & {4{agent_den[i]}}). Zero latency.
- A disabled agent's data is ignored even if nonzero.

Tracker FSM:
- UNLOCKED: phase_valid=0, phase holds 0. On sync=1: go to LOCKED, phase=0 next cycle.
- LOCKED: phase_valid=1, phase increments mod 8 each cycle.
  - sync=1 while phase==7: normal; phase wraps to 0.
  - sync=1 while phase!=7: sync_lost pulse next cycle; phase forced to 0 (relock); stay LOCKED.
  - phase==7 and sync=0: sync_lost pulse next cycle; go UNLOCKED.

Contention and owner:
- Evaluated every cycle, independent of lock state.
- popcount(agent_den) >= 2: contention=1 next cycle, and err_cnt increments, saturating at all-ones.
- err_clr has priority over a simultaneous increment: err_cnt=0.
- owner and owner_valid are registered from the same cycle as the contention decision.

Bank select:
- When phase_valid=1, phase==2 (A3) and cm_ram != 0, bank_sel <= cm_ram next cycle.
- If cm_ram has multiple bits set, bank_sel takes that multi-hot value unchanged.
- cm_ram == 0 at A3 holds bank_sel.
- cm_ram is ignored in all other phases and while UNLOCKED.

Optional Feature:
MCS4_BUS_HUB_PRIORITY_EN:
- Defined: dbus = agent_dout of the lowest-index enabled agent only; higher-index drivers are masked. Contention detection and counting are unchanged.
- Undefined: dbus is the OR merge described above.

Test Plan:
- Reset: hold rst=0, toggle inputs -> all outputs at reset values; bank_sel=4'b0001.
- Lock: pulse sync at cycle 10 and every 8 cycles after -> phase 0..7 repeating from cycle 11; phase_valid=1 from cycle 11; sync_lost never pulses.
- Misalignment: once locked, pulse sync with phase==3 -> sync_lost=1 for one cycle, phase=0 next. Then omit sync at phase 7 -> sync_lost pulse, phase_valid=0.
- Contention: agent_den=0b101 (agents 0 and 2) with dout 4'h3 and 4'h4 -> dbus=4'h7 (4'h3 with PRIORITY_EN); next cycle contention=1, owner=0, err_cnt=1. Repeat 300 cycles with ERR_CNT_W=8 -> err_cnt=255. Assert err_clr in a contention cycle -> err_cnt=0.
- Bank select: locked, cm_ram=4'b0100 at A3 -> bank_sel=4'b0100. cm_ram=4'b1000 at M1 -> bank_sel unchanged. Unlocked, cm_ram=4'b0010 -> unchanged.
- Parametrisation: N_ROM=1, RAM_BANKS=1, BANK_CHIPS=1 (N_AGENT=3) -> merge, owner=2 for a sole agent 2 driver, lock behaviour all correct.
